// File: rtl/ram_2p_sync_init.sv
// Two-port register-file RAM: registered read with valid strobe, per-lane write mask,
// post-reset hardware clear. Define RAM_2P_BYPASS_EN for same-address write-to-read forwarding.

module ram_2p_sync_init_merge #(
  parameter int WIDTH = 72,
  parameter int GRAN  = 8,
  parameter int LANES = WIDTH / GRAN
) (
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] new_i,
  input  logic [LANES-1:0] mask_i,
  output logic [WIDTH-1:0] merged_o
);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign merged_o[l*GRAN +: GRAN] = mask_i[l] ? new_i[l*GRAN +: GRAN] : old_i[l*GRAN +: GRAN];
  end
endmodule

module ram_2p_sync_init #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 72,
  parameter int MASK_GRAN = 8,
  parameter int ADDR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  parameter int LANES     = WIDTH / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [LANES-1:0]  W0_mask,
  output logic              init_busy
);
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // One extra bit so the range check stays meaningful when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0]  R0_data_q, R0_data_d;
  logic              R0_valid_q, R0_valid_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              ready, wr_in_rng, rd_in_rng, wr_we;
  logic [WIDTH-1:0]  wr_old, wr_merged, rd_stored, rd_val;

  assign ready     = (state_q == ST_READY);
  assign wr_in_rng = ({1'b0, W0_addr} < DEPTH_W);
  assign rd_in_rng = ({1'b0, R0_addr} < DEPTH_W);
  assign wr_we     = ready & W0_en & wr_in_rng;
  assign wr_old    = wr_in_rng ? mem_q[W0_addr] : '0;
  assign rd_stored = rd_in_rng ? mem_q[R0_addr] : '0;

  ram_2p_sync_init_merge #(.WIDTH(WIDTH), .GRAN(MASK_GRAN), .LANES(LANES)) u_wmerge (
    .old_i    (wr_old),
    .new_i    (W0_data),
    .mask_i   (W0_mask),
    .merged_o (wr_merged)
  );

  always_comb begin
`ifdef RAM_2P_BYPASS_EN
    // Same-address collision: wr_old is the very entry being read, so the merge is the forwarded value.
    rd_val = (wr_we && (W0_addr == R0_addr)) ? wr_merged : rd_stored;
`else
    rd_val = rd_stored;
`endif
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == LAST_IDX) begin
        state_d   = ST_READY;
        clr_cnt_d = '0;
      end
    end
    R0_valid_d = ready & R0_en;
    R0_data_d  = R0_valid_d ? rd_val : R0_data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      clr_cnt_q  <= '0;
      R0_data_q  <= '0;
      R0_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      R0_data_q  <= R0_data_d;
      R0_valid_q <= R0_valid_d;
    end
  end

  // Storage has no reset; the clear sequencer zeroes it once reset releases.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) mem_q[clr_cnt_q] <= '0;
    else if (wr_we)         mem_q[W0_addr]   <= wr_merged;
  end

  assign R0_data   = R0_data_q;
  assign R0_valid  = R0_valid_q;
  assign init_busy = (state_q == ST_INIT);
endmodule
